// File: rtl/mat_4x4_seq_multiplier.sv
// Sequential 4x4 matrix multiplier: one shared 2x2 block multiply-accumulate
// stage walks the 8 block products of C = A x B, one product per cycle.
module mat_4x4_seq_multiplier #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*DATA_W-1:0] a_flat,
  input  logic [16*DATA_W-1:0] b_flat,
  output logic                 busy,
  output logic                 done,
  output logic [16*ACC_W-1:0]  c_flat
);

  localparam int unsigned A_W = 16 * DATA_W;
  localparam int unsigned C_W = 16 * ACC_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [A_W-1:0]   a_q, a_d, b_q, b_d;
  logic [C_W-1:0]   c_q, c_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [3:0][ACC_W-1:0] prod;

  function automatic logic [ACC_W-1:0] el(input logic [A_W-1:0] m,
                                          input int unsigned r,
                                          input int unsigned c);
    return ACC_W'(m[DATA_W*(4*r+c) +: DATA_W]);
  endfunction

  // step = {bi, bj, k}: 2x2 block product A[bi][k] * B[k][bj]
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned j = 0; j < 2; j++) begin
        prod[2*i+j] =
          el(a_q, 2*32'(step_q[2]) + i, 2*32'(step_q[0]))
            * el(b_q, 2*32'(step_q[0]), 2*32'(step_q[1]) + j)
          + el(a_q, 2*32'(step_q[2]) + i, 2*32'(step_q[0]) + 1)
            * el(b_q, 2*32'(step_q[0]) + 1, 2*32'(step_q[1]) + j);
      end
    end
  end

  // next-state, operand capture and C block write/accumulate
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_flat;
          b_d     = b_flat;
          step_d  = 3'd0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < 2; i++) begin
          for (int unsigned j = 0; j < 2; j++) begin
            if (step_q[0])
              c_d[ACC_W*(4*(2*32'(step_q[2])+i) + 2*32'(step_q[1])+j) +: ACC_W] =
                c_q[ACC_W*(4*(2*32'(step_q[2])+i) + 2*32'(step_q[1])+j) +: ACC_W]
                + prod[2*i+j];
            else
              c_d[ACC_W*(4*(2*32'(step_q[2])+i) + 2*32'(step_q[1])+j) +: ACC_W] =
                prod[2*i+j];
          end
        end
        if (step_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step_d  = step_q + 3'd1;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          a_d     = a_flat;
          b_d     = b_flat;
          step_d  = 3'd0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign c_flat = c_q;

endmodule

// File: tb/tb_mat_4x4_seq_multiplier.sv
// Randomized scoreboard bench for mat_4x4_seq_multiplier against a plain
// matrix-multiply reference.
module tb_mat_4x4_seq_multiplier;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  a_flat = '0;
  logic [63:0]  b_flat = '0;
  logic         busy, done;
  logic [127:0] c_flat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int brun  = 0;

  typedef struct {
    logic [127:0] c;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  mat_4x4_seq_multiplier #(.DATA_W(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy), .done(done), .c_flat(c_flat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] res;
    int unsigned  sum;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sum = 0;
        for (int k = 0; k < 4; k++)
          sum += a[4*(4*r+k) +: 4] * b[4*(4*k+c) +: 4];
        res[8*(4*r+c) +: 8] = 8'(sum % 256);
      end
    return res;
  endfunction

  function automatic logic [63:0] fill(input logic [3:0] v);
    logic [63:0] m;
    for (int i = 0; i < 16; i++) m[4*i +: 4] = v;
    return m;
  endfunction

  function automatic logic [63:0] ident();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[4*(5*i) +: 4] = 4'd1;
    return m;
  endfunction

  function automatic logic [63:0] ramp(input int off);
    logic [63:0] m;
    for (int i = 0; i < 16; i++) m[4*i +: 4] = 4'(i + off);
    return m;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      brun = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 128'(done), 128'(0));
        end else begin
          e = sb.pop_front();
          check("c_result", c_flat, e.c);
          check("done_latency", 128'(cyc - e.cyc), 128'(9));
          check("busy_len", 128'(brun), 128'(8));
          check("busy_in_done", 128'(busy), 128'(0));
        end
      end
      if (busy) brun++;
      else brun = 0;
    end
  end

  // Drive start; acceptance edge is the next posedge
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit expect_accept);
    exp_t e;
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(posedge clk);
    if (expect_accept) begin
      e.c   = model(a, b);
      e.cyc = cyc;
      sb.push_back(e);
    end
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) check("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [127:0] cref;
    rst_n = 1'b0;
    #12;
    check("reset_state", {busy, done, c_flat}, '0);
    @(negedge clk) rst_n = 1'b1;

    // idle with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {busy, done, c_flat}, '0);
    end

    // identity x ramp, then result must hold while idle
    @(posedge clk); #1;
    issue(ident(), ramp(0), 1'b1);
    check("busy_after_start", 128'(busy), 128'(1));
    wait_done();
    repeat (3) @(negedge clk);
    check("c_hold_idle", c_flat, model(ident(), ramp(0)));

    // all 15 wraps mod 256
    @(posedge clk); #1;
    issue(fill(4'hf), fill(4'hf), 1'b1);
    wait_done();
    check("wrap_132", c_flat, {16{8'h84}});

    // back-to-back: start held in the DONE cycle
    @(posedge clk); #1;
    issue(ramp(1), ident(), 1'b1);
    wait_done();
    issue(fill(4'd1), fill(4'd1), 1'b1);
    #1 check("b2b_busy", 128'(busy), 128'(1));
    wait_done();
    check("b2b_fours", c_flat, {16{8'h04}});

    // start during RUN ignored, operands not resampled
    @(posedge clk); #1;
    issue(ident(), fill(4'd2), 1'b1);
    repeat (2) @(posedge clk);
    #1 issue(fill(4'd7), fill(4'd7), 1'b0);
    a_flat = fill(4'd7);
    b_flat = fill(4'd7);
    wait_done();
    repeat (12) @(negedge clk);
    check("ignored_twos", c_flat, {16{8'h02}});

    // async reset mid-run at step 4
    @(posedge clk); #1;
    issue(fill(4'd3), fill(4'd5), 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {busy, done, c_flat}, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle", {busy, done, c_flat}, '0);
    @(posedge clk); #1;
    issue(ramp(3), ramp(5), 1'b1);
    wait_done();

    // randomized, mixing idle gaps and back-to-back starts
    for (int t = 0; t < 12; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
      issue(ra, rb, 1'b1);
      wait_done();
      cref = model(ra, rb);
      check("rand_c", c_flat, cref);
    end

    repeat (15) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
